// File: rtl/spill_register_flushable_pkg.sv
// rtl/spill_register_flushable_pkg.sv - shared CDC payload definitions
// Purpose: one home for the payload width and type used by the 4-phase CDC
//          and its spill-register output stage, plus a small occupancy helper.
// Ports:   none (package).
package spill_register_flushable_pkg;

    localparam int unsigned CDC_DATA_WIDTH = 64;

    typedef logic [CDC_DATA_WIDTH-1:0] cdc_payload_t;

    // Occupancy of a two-slot buffer from its two full flags.
    function automatic logic [1:0] fill_count(input logic a_full, input logic b_full);
        return {1'b0, a_full} + {1'b0, b_full};
    endfunction

endpackage

// File: rtl/spill_register_flushable.sv
// rtl/spill_register_flushable.sv - two-slot flushable spill register on a valid/ready stream
// Purpose: elastic stage that registers both valid and ready paths; items appear
//          downstream one cycle after acceptance, strict FIFO, with synchronous flush.
//          BYPASS=1 degenerates to plain wires.
// Ports:
//   clk_i    in   clock
//   rst_i    in   asynchronous active-high reset (clears slot flags)
//   flush_i  in   synchronous flush, discards every buffered item
//   valid_i  in   upstream valid
//   ready_o  out  upstream ready (registered state, gated by flush_i)
//   data_i   in   upstream payload
//   valid_o  out  downstream valid
//   ready_i  in   downstream ready
//   data_o   out  downstream payload (oldest held item)
//   count_o  out  items held, 0..2
module spill_register_flushable
    import spill_register_flushable_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = CDC_DATA_WIDTH,
    parameter bit          BYPASS     = 1'b0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [1:0]            count_o
);

    generate
        if (BYPASS) begin : g_bypass
            // Clock, reset and flush have no meaning without storage.
            logic w_unused_bypass;
            assign w_unused_bypass = ^{clk_i, rst_i, flush_i};

            assign valid_o = valid_i;
            assign ready_o = ready_i;
            assign data_o  = data_i;
            assign count_o = 2'd0;
        end else begin : g_spill
            // Slot A receives new items; slot B holds the older item when A
            // could not leave because the consumer stalled.
            logic                  r_a_full;
            logic                  r_b_full;
            logic [DATA_WIDTH-1:0] r_a_data;
            logic [DATA_WIDTH-1:0] r_b_data;

            logic w_ready;
            logic w_a_fill;
            logic w_a_drain;
            logic w_b_fill;
            logic w_b_drain;

            assign w_ready   = (!r_a_full || !r_b_full) && !flush_i;
            assign w_a_fill  = valid_i && w_ready;
            // A only leaves when B is empty, so B is always the older item.
            assign w_a_drain = r_a_full && !r_b_full;
            assign w_b_fill  = w_a_drain && !ready_i;
            assign w_b_drain = r_b_full && ready_i;

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    r_a_full <= 1'b0;
                    r_b_full <= 1'b0;
                end else if (flush_i) begin
                    r_a_full <= 1'b0;
                    r_b_full <= 1'b0;
                end else begin
                    if (w_a_fill) begin
                        r_a_full <= 1'b1;
                    end else if (w_a_drain) begin
                        r_a_full <= 1'b0;
                    end
                    if (w_b_fill) begin
                        r_b_full <= 1'b1;
                    end else if (w_b_drain) begin
                        r_b_full <= 1'b0;
                    end
                end
            end

            // Payload registers carry no reset; the full flags qualify them.
            always_ff @(posedge clk_i) begin
                if (w_a_fill) begin
                    r_a_data <= data_i;
                end
                if (w_b_fill && !flush_i) begin
                    r_b_data <= r_a_data;
                end
            end

            assign ready_o = w_ready;
            assign valid_o = (r_a_full || r_b_full) && !flush_i;
            assign data_o  = r_b_full ? r_b_data : r_a_data;
            assign count_o = fill_count(r_a_full, r_b_full);

            a_no_fill_when_full: assert property (@(posedge clk_i) disable iff (rst_i)
                !(w_a_fill && r_a_full && r_b_full));

            a_hold_while_stalled: assert property (@(posedge clk_i) disable iff (rst_i)
                (valid_o && !ready_i && !flush_i) |=> (flush_i || (valid_o && $stable(data_o))));

            a_count_range: assert property (@(posedge clk_i) disable iff (rst_i)
                count_o <= 2'd2);
        end
    endgenerate

endmodule

// File: tb/tb_spill_register_flushable.sv
// tb/tb_spill_register_flushable.sv - scoreboard bench for spill_register_flushable
module tb_spill_register_flushable;
    import spill_register_flushable_pkg::*;

    logic         clk = 1'b0;
    logic         rst_i;
    logic         flush_i;
    logic         valid_i;
    logic         ready_o;
    cdc_payload_t data_i;
    logic         valid_o;
    logic         ready_i;
    cdc_payload_t data_o;
    logic [1:0]   count_o;

    logic         bp_flush_i;
    logic         bp_valid_i;
    logic         bp_ready_o;
    cdc_payload_t bp_data_i;
    logic         bp_valid_o;
    logic         bp_ready_i;
    cdc_payload_t bp_data_o;
    logic [1:0]   bp_count_o;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_out = 0;
    bit done  = 1'b0;

    cdc_payload_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spill_register_flushable #(.DATA_WIDTH(CDC_DATA_WIDTH), .BYPASS(1'b0)) dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_i  (data_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .data_o  (data_o),
        .count_o (count_o)
    );

    spill_register_flushable #(.DATA_WIDTH(CDC_DATA_WIDTH), .BYPASS(1'b1)) dut_bp (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .flush_i (bp_flush_i),
        .valid_i (bp_valid_i),
        .ready_o (bp_ready_o),
        .data_i  (bp_data_i),
        .valid_o (bp_valid_o),
        .ready_i (bp_ready_i),
        .data_o  (bp_data_o),
        .count_o (bp_count_o)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference model: the buffer holds exactly the accepted-but-not-emitted
    // items, at most two; flush and reset forget them all.
    always @(negedge clk) begin
        int sz;
        sz = exp_q.size();
        if (rst_i) begin
            chk("rst_valid", valid_o, 1'b0);
            chk("rst_ready", ready_o, 1'b1);
            chk("rst_count", count_o, 2'd0);
            exp_q.delete();
        end else if (flush_i) begin
            chk("flush_valid", valid_o, 1'b0);
            chk("flush_ready", ready_o, 1'b0);
            chk("flush_count", count_o, sz);
            exp_q.delete();
        end else begin
            chk("count", count_o, sz);
            chk("ready", ready_o, sz < 2);
            chk("valid", valid_o, sz > 0);
            if (sz > 0) begin
                chk("data", data_o, exp_q[0]);
                if (ready_i) begin
                    void'(exp_q.pop_front());
                    n_out++;
                end
            end
            if (valid_i && sz < 2) begin
                exp_q.push_back(data_i);
            end
        end
    end

    always @(negedge clk) begin
        chk("bp_valid", bp_valid_o, bp_valid_i);
        chk("bp_ready", bp_ready_o, bp_ready_i);
        chk("bp_data",  bp_data_o,  bp_data_i);
        chk("bp_count", bp_count_o, 2'd0);
    end

    initial begin
        bp_flush_i = 1'b0;
        bp_valid_i = 1'b0;
        bp_ready_i = 1'b0;
        bp_data_i  = '0;
        while (!done) begin
            @(posedge clk);
            #2;
            bp_flush_i = 1'($urandom_range(0, 1));
            bp_valid_i = 1'($urandom_range(0, 1));
            bp_ready_i = 1'($urandom_range(0, 1));
            bp_data_i  = {$urandom, $urandom};
        end
    end

    task automatic send(input cdc_payload_t d);
        int n;
        n = 0;
        valid_i = 1'b1;
        data_i  = d;
        do begin
            @(negedge clk);
            n++;
        end while (!ready_o && n < 64);
        chk("send_accept", ready_o, 1'b1);
        @(posedge clk);
        #2;
        valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        int t0;
        int n;
        rst_i   = 1'b1;
        flush_i = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b0;
        data_i  = '0;
        idle(3);
        rst_i = 1'b0;
        idle(1);

        // Reset with two items buffered.
        send(64'h11);
        send(64'h22);
        @(negedge clk);
        chk("t1_count_before", count_o, 2'd2);
        @(posedge clk);
        #3;
        rst_i = 1'b1;
        #1;
        chk("t1_valid_immediate", valid_o, 1'b0);
        chk("t1_ready_immediate", ready_o, 1'b1);
        chk("t1_count_immediate", count_o, 2'd0);
        idle(2);
        rst_i   = 1'b0;
        ready_i = 1'b1;
        idle(4);

        // Back-to-back streaming.
        ready_i = 1'b1;
        t0 = cyc;
        for (int i = 1; i <= 16; i++) send(64'(i));
        chk("t2_throughput", 64'(cyc - t0), 64'd16);
        idle(3);

        // Backpressure.
        ready_i = 1'b0;
        send(64'hA);
        send(64'hB);
        valid_i = 1'b1;
        data_i  = 64'hC;
        repeat (3) @(negedge clk);
        chk("t3_ready", ready_o, 1'b0);
        chk("t3_count", count_o, 2'd2);
        chk("t3_head", data_o, 64'hA);
        @(posedge clk);
        #2;
        ready_i = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ready_o && n < 64);
        chk("t3_c_accept", ready_o, 1'b1);
        @(posedge clk);
        #2;
        valid_i = 1'b0;
        idle(4);

        // Simultaneous input and output at count 1.
        ready_i = 1'b0;
        send(64'h5);
        ready_i = 1'b1;
        valid_i = 1'b1;
        data_i  = 64'h6;
        @(negedge clk);
        chk("t4_head_old", data_o, 64'h5);
        @(posedge clk);
        #2;
        valid_i = 1'b0;
        @(negedge clk);
        chk("t4_count", count_o, 2'd1);
        chk("t4_head_new", data_o, 64'h6);
        idle(3);

        // Flush with input offered in the same cycle.
        ready_i = 1'b0;
        send(64'h31);
        send(64'h32);
        flush_i = 1'b1;
        valid_i = 1'b1;
        data_i  = 64'h77;
        @(negedge clk);
        chk("t5_ready_flush", ready_o, 1'b0);
        chk("t5_valid_flush", valid_o, 1'b0);
        @(posedge clk);
        #2;
        flush_i = 1'b0;
        valid_i = 1'b0;
        @(negedge clk);
        chk("t5_count_after", count_o, 2'd0);
        @(posedge clk);
        #2;
        send(64'h78);
        @(negedge clk);
        chk("t5_next_valid", valid_o, 1'b1);
        chk("t5_next_data", data_o, 64'h78);
        ready_i = 1'b1;
        idle(3);

        // Random traffic with occasional flush.
        repeat (3000) begin
            valid_i = 1'($urandom_range(0, 1));
            ready_i = ($urandom_range(0, 3) != 0);
            flush_i = ($urandom_range(0, 31) == 0);
            data_i  = {$urandom, $urandom};
            idle(1);
        end
        valid_i = 1'b0;
        flush_i = 1'b0;
        ready_i = 1'b1;
        idle(4);
        chk("items_emitted", n_out > 500, 1'b1);
        chk("final_empty", count_o, 2'd0);

        done = 1'b1;
        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
